// File: rtl/capture_pkg.sv
// capture_pkg: shared frame FSM states, sync bytes and field widths
package capture_pkg;
    localparam int LEN_W = 10;
    localparam int EVT_W = 8;
    localparam int WORD_W = 16;
    localparam logic [7:0] SYNC0_DEF = 8'hAA;
    localparam logic [7:0] SYNC1_DEF = 8'h55;
    localparam logic [23:0] TIMEOUT_DEF = 24'd1_000_000;
    typedef enum logic [10:0] {
        IDLE  = 11'b000_0000_0001,
        S0    = 11'b000_0000_0010,
        S1    = 11'b000_0000_0100,
        LEN_H = 11'b000_0000_1000,
        LEN_L = 11'b000_0001_0000,
        EVT   = 11'b000_0010_0000,
        FETCH = 11'b000_0100_0000,
        WAITV = 11'b000_1000_0000,
        HI    = 11'b001_0000_0000,
        LO    = 11'b010_0000_0000,
        CHK   = 11'b100_0000_0000
    } state_e;
endpackage

// File: rtl/byte_tx_slot.sv
// byte_tx_slot: one-entry valid/ready output register feeding the byte link
module byte_tx_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid
);
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    always_comb begin
        data_d  = load ? load_data : data_q;
        valid_d = load | (valid_q & ~tx_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data  = data_q;
    assign tx_valid = valid_q;
endmodule

// File: rtl/capture_frame_transmitter.sv
// capture_frame_transmitter: drains the capture FIFO and sends one framed,
// checksummed byte stream per trigger batch to the host link
module capture_frame_transmitter
    import capture_pkg::*;
#(
    parameter logic [7:0]  SYNC0          = SYNC0_DEF,
    parameter logic [7:0]  SYNC1          = SYNC1_DEF,
    parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dataReadyToRead,
    input  logic              dataValid,
    input  logic [WORD_W-1:0] dataOut,
    output logic              dataRead,
    output logic              readyToTransmit,
    input  logic [LEN_W-1:0]  dataLength,
    input  logic [EVT_W-1:0]  numEventsToAdd,
    output logic [7:0]        txData,
    output logic              txValid,
    input  logic              txReady,
    output logic              frameDone,
    output logic              frameAbort
);
    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic [EVT_W-1:0]  evt_q, evt_d;
    logic [7:0]        cks_q, cks_d, lo_q, lo_d, cks_acc, load_data;
    logic [23:0]       tcnt_q, tcnt_d;
    logic              rtt_q, rtt_d, done_q, done_d, abort_q, abort_d;
    logic              load, accept, timeout;

    assign accept  = txValid & txReady;
    assign timeout = tcnt_q == TIMEOUT_CYCLES - 24'd1;
    assign cks_acc = cks_q + txData;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        evt_d     = evt_q;
        cnt_d     = cnt_q;
        cks_d     = cks_q;
        lo_d      = lo_q;
        tcnt_d    = tcnt_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        load      = 1'b0;
        load_data = 8'h00;
        case (state_q)
            IDLE: if (dataReadyToRead) begin
                len_d     = dataLength;
                evt_d     = numEventsToAdd;
                cks_d     = 8'h00;
                cnt_d     = '0;
                tcnt_d    = '0;
                load      = 1'b1;
                load_data = SYNC0;
                state_d   = S0;
            end
            S0: if (accept) begin
                load      = 1'b1;
                load_data = SYNC1;
                state_d   = S1;
            end
            S1: if (accept) begin
                load      = 1'b1;
                load_data = {6'b0, len_q[9:8]};
                state_d   = LEN_H;
            end
            LEN_H: if (accept) begin
                cks_d     = cks_acc;
                load      = 1'b1;
                load_data = len_q[7:0];
                state_d   = LEN_L;
            end
            LEN_L: if (accept) begin
                cks_d     = cks_acc;
                load      = 1'b1;
                load_data = evt_q;
                state_d   = EVT;
            end
            EVT: if (accept) begin
                cks_d     = cks_acc;
                tcnt_d    = '0;
                load      = len_q == '0;
                load_data = cks_acc;
                state_d   = len_q == '0 ? CHK : FETCH;
            end
            FETCH: begin
                tcnt_d = tcnt_q + 24'd1;
                if (dataReadyToRead) state_d = WAITV;
                else if (timeout) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WAITV: begin
                tcnt_d = tcnt_q + 24'd1;
                if (dataValid) begin
                    lo_d      = dataOut[7:0];
                    tcnt_d    = '0;
                    load      = 1'b1;
                    load_data = dataOut[15:8];
                    state_d   = HI;
                end else if (timeout) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
            end
            HI: if (accept) begin
                cks_d     = cks_acc;
                load      = 1'b1;
                load_data = lo_q;
                state_d   = LO;
            end
            LO: if (accept) begin
                cks_d     = cks_acc;
                cnt_d     = cnt_q + LEN_W'(1);
                tcnt_d    = '0;
                load      = cnt_d == len_q;
                load_data = cks_acc;
                state_d   = cnt_d == len_q ? CHK : FETCH;
            end
            CHK: if (accept) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rtt_d = state_d == IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            evt_q   <= '0;
            cnt_q   <= '0;
            cks_q   <= 8'h00;
            lo_q    <= 8'h00;
            tcnt_q  <= '0;
            rtt_q   <= 1'b1;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
            cks_q   <= cks_d;
            lo_q    <= lo_d;
            tcnt_q  <= tcnt_d;
            rtt_q   <= rtt_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    // Read strobe follows the FIFO flag in the same cycle so a word costs only 4 cycles
    assign dataRead        = (state_q == FETCH) & dataReadyToRead;
    assign readyToTransmit = rtt_q;
    assign frameDone       = done_q;
    assign frameAbort      = abort_q;

    byte_tx_slot u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_data(load_data),
        .tx_ready (txReady),
        .tx_data  (txData),
        .tx_valid (txValid)
    );
endmodule

// File: tb/tb_capture_frame_transmitter.sv
// tb_capture_frame_transmitter: scoreboard bench; stimulus queues expected
// bytes, a negedge monitor pops and compares every accepted byte
module tb_capture_frame_transmitter;
    logic        clk = 0, rst = 1, dataValid = 0, txReady = 1, kick = 0;
    logic        dataReadyToRead, dataRead, readyToTransmit, txValid, frameDone, frameAbort;
    logic [15:0] dataOut = 16'h0;
    logic [9:0]  dataLength = 10'd0;
    logic [7:0]  numEventsToAdd = 8'd0, txData;
    logic [15:0] fifo[$];
    logic [7:0]  exp_q[$];
    int          n_vec = 0, n_err = 0, cyc = 0, rd_count = 0, done_cnt = 0, abort_cnt = 0;
    int          n_acc = 0, last_acc_cyc = 0, abort_cyc = 0;
    logic        rtt_at_abort = 0, txv_at_abort = 0, chk_stall = 0, prev_stall = 0, pat_en = 0;
    logic [7:0]  prev_data = 8'h0;

    assign dataReadyToRead = kick | (fifo.size() != 0);

    capture_frame_transmitter #(.TIMEOUT_CYCLES(24'd16)) dut (
        .clk(clk), .rst(rst), .dataReadyToRead(dataReadyToRead), .dataValid(dataValid),
        .dataOut(dataOut), .dataRead(dataRead), .readyToTransmit(readyToTransmit),
        .dataLength(dataLength), .numEventsToAdd(numEventsToAdd), .txData(txData),
        .txValid(txValid), .txReady(txReady), .frameDone(frameDone), .frameAbort(frameAbort)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares every accepted byte and the stall-hold rule
    always @(negedge clk) begin
        if (chk_stall && prev_stall) begin
            check("stall_valid_held", 32'(txValid), 1);
            check("stall_data_held", 32'(txData), 32'(prev_data));
        end
        prev_stall = txValid & ~txReady;
        prev_data  = txData;
        if (txValid && txReady) begin
            n_acc++;
            last_acc_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL extra_byte: got %0h expected none", txData);
            end else check("byte", 32'(txData), 32'(exp_q.pop_front()));
        end
        if (frameDone) done_cnt++;
        if (frameAbort) begin
            abort_cnt++;
            abort_cyc    = cyc;
            rtt_at_abort = readyToTransmit;
            txv_at_abort = txValid;
        end
    end

    // FIFO model: dataOut valid exactly one cycle after a read
    initial forever begin
        @(negedge clk);
        if (dataRead) begin
            rd_count++;
            if (!dataReadyToRead) begin
                n_vec++;
                n_err++;
                $display("FAIL read_when_empty: got dataRead=1 expected 0");
            end
            @(posedge clk);
            #1;
            dataOut   = fifo.size() != 0 ? fifo.pop_front() : 16'hDEAD;
            dataValid = 1;
            @(posedge clk);
            #1;
            dataValid = 0;
        end
    end

    task automatic push_frame(input logic [9:0] len, input logic [7:0] ev, input logic [15:0] w[$], input bit load_fifo);
        logic [7:0] s;
        s = {6'b0, len[9:8]} + len[7:0] + ev;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back({6'b0, len[9:8]});
        exp_q.push_back(len[7:0]);
        exp_q.push_back(ev);
        foreach (w[i]) begin
            exp_q.push_back(w[i][15:8]);
            exp_q.push_back(w[i][7:0]);
            s = s + w[i][15:8] + w[i][7:0];
        end
        exp_q.push_back(s);
        if (load_fifo) foreach (w[i]) fifo.push_back(w[i]);
    endtask

    task automatic wait_end(input int max_cyc);
        int ev0 = done_cnt + abort_cnt;
        bit ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (pat_en) txReady = (i % 4 == 0) || (i % 4 == 3);
            if (done_cnt + abort_cnt != ev0 && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check("frame_end_in_budget", 32'(ok), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txValid"}, 32'(txValid), 0);
        check({tag, "_txData"}, 32'(txData), 0);
        check({tag, "_dataRead"}, 32'(dataRead), 0);
        check({tag, "_frameDone"}, 32'(frameDone), 0);
        check({tag, "_frameAbort"}, 32'(frameAbort), 0);
        check({tag, "_readyToTransmit"}, 32'(readyToTransmit), 1);
    endtask

    initial begin
        int r0, d0, a0, acc0;
        bit ok;
        logic [15:0] w[$];
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 0;

        // basic frame, link always ready
        dataLength = 10'd3; numEventsToAdd = 8'd8;
        r0 = rd_count; d0 = done_cnt;
        exp_q = {8'hAA, 8'h55, 8'h00, 8'h03, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'h13};
        fifo = {16'h0102, 16'h0304, 16'hFFFF};
        wait_end(200);
        check("t1_done_pulses", 32'(done_cnt - d0), 1);
        check("t1_reads", 32'(rd_count - r0), 3);

        // same frame with txReady toggling 1-0-0-1
        r0 = rd_count; d0 = done_cnt;
        chk_stall = 1; pat_en = 1;
        exp_q = {8'hAA, 8'h55, 8'h00, 8'h03, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'h13};
        fifo = {16'h0102, 16'h0304, 16'hFFFF};
        wait_end(400);
        pat_en = 0; chk_stall = 0; txReady = 1;
        check("t2_done_pulses", 32'(done_cnt - d0), 1);
        check("t2_reads", 32'(rd_count - r0), 3);

        // zero-length frame
        dataLength = 10'd0; numEventsToAdd = 8'd1;
        r0 = rd_count; d0 = done_cnt;
        exp_q = {8'hAA, 8'h55, 8'h00, 8'h00, 8'h01, 8'h01};
        check("t3_rtt_before", 32'(readyToTransmit), 1);
        kick = 1;
        @(posedge clk);
        #1;
        kick = 0;
        check("t3_rtt_during", 32'(readyToTransmit), 0);
        wait_end(100);
        @(posedge clk);
        #1;
        check("t3_rtt_after", 32'(readyToTransmit), 1);
        check("t3_reads", 32'(rd_count - r0), 0);
        check("t3_done_pulses", 32'(done_cnt - d0), 1);

        // starved FIFO: second word never arrives
        dataLength = 10'd2; numEventsToAdd = 8'd5;
        r0 = rd_count; d0 = done_cnt; a0 = abort_cnt;
        exp_q = {8'hAA, 8'h55, 8'h00, 8'h02, 8'h05, 8'hA1, 8'hB2};
        fifo = {16'hA1B2};
        wait_end(200);
        check("t4_abort_pulses", 32'(abort_cnt - a0), 1);
        check("t4_done_pulses", 32'(done_cnt - d0), 0);
        check("t4_abort_latency", 32'(abort_cyc - last_acc_cyc), 17);
        check("t4_rtt_at_abort", 32'(rtt_at_abort), 1);
        check("t4_txvalid_at_abort", 32'(txv_at_abort), 0);
        check("t4_reads", 32'(rd_count - r0), 1);
        @(posedge clk);
        #1;
        check("t4_rtt_after", 32'(readyToTransmit), 1);

        // reset during HI of word 2, then clean restart from SYNC0
        dataLength = 10'd4; numEventsToAdd = 8'd2;
        d0 = done_cnt; acc0 = n_acc;
        w = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        push_frame(10'd4, 8'd2, w, 1);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (n_acc - acc0 >= 7) begin ok = 1; break; end
        end
        check("t5_reach_word2", 32'(ok), 1);
        txReady = 0;
        dataLength = 10'd2;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (txValid) begin ok = 1; break; end
        end
        check("t5_hi_presented", 32'(ok), 1);
        check("t5_hi_byte", 32'(txData), 32'h22);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        check_reset_outputs("t5_rst");
        exp_q.delete();
        w = {16'h3333, 16'h4444};
        push_frame(10'd2, 8'd2, w, 0);
        txReady = 1;
        wait_end(200);
        check("t5_done_pulses", 32'(done_cnt - d0), 1);

        // maximum length, checksum wrap, dataLength changed mid-frame
        dataLength = 10'd1023; numEventsToAdd = 8'd4;
        r0 = rd_count; d0 = done_cnt;
        w.delete();
        for (int i = 0; i < 1023; i++) w.push_back(16'hFFFF);
        push_frame(10'd1023, 8'd4, w, 1);
        repeat (40) @(posedge clk);
        #1;
        dataLength = 10'd5;
        wait_end(6000);
        check("t6_done_pulses", 32'(done_cnt - d0), 1);
        check("t6_reads", 32'(rd_count - r0), 1023);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
